console_ctrl: RTL

CONSOLE_CTRL -- requirements
Module: console_ctrl

---
 rtl/console_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/console_ctrl.sv
// Text console controller: turns key bytes into text-memory writes and cursor moves, with full-screen clear on wrap.
// Optional cursor blink is built only when CONSOLE_BLINK_EN is defined.
module console_ctrl #(
  parameter int COLS      = 70,
  parameter int ROWS      = 30,
  parameter int BLINK_DIV = 12500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [7:0]  key_ascii,
  output logic        key_ready,
  output logic        wr_en,
  output logic [11:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [6:0]  cur_x,
  output logic [4:0]  cur_y,
  output logic        busy,
  output logic        cursor_on
);

  localparam logic [6:0] X_MAX = 7'(COLS - 1);
  localparam logic [4:0] Y_MAX = 5'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

  state_t     state;
  logic       adv_pending;
  logic [6:0] clr_x;
  logic [4:0] clr_y;
  logic [6:0] clr_x_nxt;
  logic [4:0] clr_y_nxt;
  logic       accept;
  logic       is_print;
  logic       is_enter;
  logic       is_bs;

  assign key_ready = (state == IDLE) && !reset;
  assign busy      = (state != IDLE);
  assign accept    = key_valid && key_ready;
  assign is_print  = (key_ascii >= 8'h20) && (key_ascii <= 8'h7E);
  assign is_enter  = (key_ascii == 8'h0A) || (key_ascii == 8'h0D);
  assign is_bs     = (key_ascii == 8'h08);

  always_comb begin
    clr_x_nxt = clr_x + 7'd1;
    clr_y_nxt = clr_y;
    if (clr_x == X_MAX) begin
      clr_x_nxt = '0;
      clr_y_nxt = clr_y + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      adv_pending <= 1'b0;
      cur_x       <= '0;
      cur_y       <= '0;
      clr_x       <= '0;
      clr_y       <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
    end else begin
      case (state)
        IDLE: begin
          wr_en <= 1'b0;
          if (accept) begin
            if (is_print) begin
              state       <= WRITE;
              adv_pending <= 1'b1;
              wr_en       <= 1'b1;
              wr_addr     <= {cur_x, cur_y};
              wr_data     <= key_ascii;
            end else if (is_enter) begin
              if (cur_y == Y_MAX) begin
                state   <= CLEAR;
                cur_x   <= '0;
                cur_y   <= '0;
                clr_x   <= '0;
                clr_y   <= '0;
                wr_en   <= 1'b1;
                wr_addr <= '0;
                wr_data <= '0;
              end else begin
                cur_x <= '0;
                cur_y <= cur_y + 5'd1;
              end
            end else if (is_bs) begin
              // The cursor retreats at acceptance; WRITE then blanks the cell it lands on.
              if (cur_x != '0) begin
                state       <= WRITE;
                adv_pending <= 1'b0;
                cur_x       <= cur_x - 7'd1;
                wr_en       <= 1'b1;
                wr_addr     <= {cur_x - 7'd1, cur_y};
                wr_data     <= '0;
              end else if (cur_y != '0) begin
                state       <= WRITE;
                adv_pending <= 1'b0;
                cur_x       <= X_MAX;
                cur_y       <= cur_y - 5'd1;
                wr_en       <= 1'b1;
                wr_addr     <= {X_MAX, cur_y - 5'd1};
                wr_data     <= '0;
              end
            end
          end
        end
        WRITE: begin
          state       <= IDLE;
          wr_en       <= 1'b0;
          adv_pending <= 1'b0;
          if (adv_pending) begin
            if (cur_x != X_MAX) begin
              cur_x <= cur_x + 7'd1;
            end else if (cur_y != Y_MAX) begin
              cur_x <= '0;
              cur_y <= cur_y + 5'd1;
            end else begin
              state   <= CLEAR;
              cur_x   <= '0;
              cur_y   <= '0;
              clr_x   <= '0;
              clr_y   <= '0;
              wr_en   <= 1'b1;
              wr_addr <= '0;
              wr_data <= '0;
            end
          end
        end
        CLEAR: begin
          if ((clr_x == X_MAX) && (clr_y == Y_MAX)) begin
            state <= IDLE;
            wr_en <= 1'b0;
            cur_x <= '0;
            cur_y <= '0;
          end else begin
            clr_x   <= clr_x_nxt;
            clr_y   <= clr_y_nxt;
            wr_addr <= {clr_x_nxt, clr_y_nxt};
          end
        end
        default: begin
          state <= IDLE;
          wr_en <= 1'b0;
        end
      endcase
    end
  end

`ifdef CONSOLE_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV + 1);

  logic [BW-1:0] blink_cnt;
  logic          blink_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt <= '0;
      blink_q   <= 1'b1;
    end else if (accept) begin
      blink_cnt <= '0;
      blink_q   <= 1'b1;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink_q   <= ~blink_q;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign cursor_on = blink_q;
`else
  assign cursor_on = 1'b1;
`endif

endmodule
